// File: rtl/alu_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_pkg
// Purpose  : Shared widths, opcode constants and FSM state encoding for the
//            execute-stage ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_exec_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int PC_W   = 8;
  localparam int OP_W   = 3;
  localparam int RET_W  = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_W-1:0] OP_CMP  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
  localparam logic [OP_W-1:0] OP_EQ   = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_WB     = 3'd3,
    ST_BR     = 3'd4
  } state_e;

  // Opcodes 000 and 111 have no ALU function assigned.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return (op == 3'b000) || (op == 3'b111);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_if
// Purpose  : Bundles the issue, ALU, writeback and branch-resolve signals of
//            the execute-stage sequencer. master = sequencer, slave = its
//            environment (decode, ALU, register file, PC logic).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_ctrl_if;
  import alu_exec_ctrl_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [PC_W-1:0]   issue_pc;
  logic [PC_W-1:0]   issue_off;

  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;

  logic              br_valid;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;

  logic              err;
  logic [RET_W-1:0]  retired;

  modport master (
    input  issue_valid, issue_op, issue_a, issue_b, issue_pc, issue_off,
    input  alu_result, alu_zero, wb_ready,
    output issue_ready, alu_data1, alu_data2,
    output wb_valid, wb_data, br_valid, br_taken, br_target, err, retired
  );

  modport slave (
    output issue_valid, issue_op, issue_a, issue_b, issue_pc, issue_off,
    output alu_result, alu_zero, wb_ready,
    input  issue_ready, alu_data1, alu_data2,
    input  wb_valid, wb_data, br_valid, br_taken, br_target, err, retired
  );

endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl_branch_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_calc
// Purpose  : Next-PC computation for a resolved equality branch.
//            taken     -> pc + 1 + sext(off)
//            not taken -> pc + 1
//            Offset width equals PC width, so sign extension is implicit and
//            the sum wraps modulo 2^PC_W.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_calc
  import alu_exec_ctrl_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] off_i,
  input  logic            taken_i,
  output logic [PC_W-1:0] target_o
);

  // Fall-through address plus the offset when the branch is taken.
  always_comb begin
    target_o = pc_i + PC_W'(1) + (taken_i ? off_i : '0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Execute-stage sequencer for the 8-bit core. Accepts one decoded
//            instruction, drives the combinational ALU, samples its outputs a
//            cycle later and routes the outcome to writeback or to the
//            branch-resolve port (equality op).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_exec_ctrl_if.master bus
);

  state_e            state_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   off_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;

  logic              issue_ready_q;
  logic [DATA_W-1:0] alu_d1_q;
  logic [DATA_W-1:0] alu_d2_q;
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              br_valid_q;
  logic              br_taken_q;
  logic [PC_W-1:0]   br_target_q;
  logic              err_q;
  logic [RET_W-1:0]  retired_q;

  logic [PC_W-1:0]   br_target_d;

  branch_target_calc u_branch_target_calc (
    .pc_i     (pc_q),
    .off_i    (off_q),
    .taken_i  (zero_q),
    .target_o (br_target_d)
  );

  // Sequencer FSM with all outputs registered; err and br_valid are pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= '0;
      off_q         <= '0;
      res_q         <= '0;
      zero_q        <= 1'b0;
      issue_ready_q <= 1'b0;
      alu_d1_q      <= '0;
      alu_d2_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      br_valid_q    <= 1'b0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      err_q         <= 1'b0;
      retired_q     <= '0;
    end else begin
      err_q      <= 1'b0;
      br_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          issue_ready_q <= 1'b1;
          if (bus.issue_valid && issue_ready_q) begin
            op_q  <= bus.issue_op;
            a_q   <= bus.issue_a;
            b_q   <= bus.issue_b;
            pc_q  <= bus.issue_pc;
            off_q <= bus.issue_off;
            if (is_illegal_op(bus.issue_op)) begin
              err_q <= 1'b1;
            end else begin
              issue_ready_q <= 1'b0;
              state_q       <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          // Both operands change on the same edge so the ALU settles once.
          alu_d1_q <= a_q;
          alu_d2_q <= b_q;
          state_q  <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          res_q   <= bus.alu_result;
          zero_q  <= bus.alu_zero;
          state_q <= (op_q == OP_EQ) ? ST_BR : ST_WB;
        end
        ST_WB: begin
          if (!wb_valid_q) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= res_q;
          end else if (bus.wb_ready) begin
            wb_valid_q    <= 1'b0;
            retired_q     <= retired_q + RET_W'(1);
            issue_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        ST_BR: begin
          br_valid_q    <= 1'b1;
          br_taken_q    <= zero_q;
          br_target_q   <= br_target_d;
          retired_q     <= retired_q + RET_W'(1);
          issue_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.alu_data1   = alu_d1_q;
  assign bus.alu_data2   = alu_d2_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.br_valid    = br_valid_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.br_target   = br_target_q;
  assign bus.err         = err_q;
  assign bus.retired     = retired_q;

endmodule
`default_nettype wire
